// File: rtl/edge_qualifier.sv
// Debounces an already-synchronized level, emits rise/fall strobes, counts accepted
// edges (saturating) and keeps a single-entry timestamped event register with backpressure.
module edge_qualifier #(
    parameter int unsigned FILTER_CYCLES = 3,
    parameter int unsigned CNT_WIDTH     = 8,
    parameter int unsigned TS_WIDTH      = 16
) (
    input  logic                 clk_B,
    input  logic                 reset,
    input  logic                 B_sync,
    input  logic                 clear,
    output logic                 level,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] rise_count,
    output logic [CNT_WIDTH-1:0] fall_count,
    output logic                 count_sat,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic                 evt_rise,
    output logic [TS_WIDTH-1:0]  evt_time,
    output logic                 evt_dropped
);

    typedef enum logic [1:0] {
        STABLE_LO,
        QUAL_HI,
        STABLE_HI,
        QUAL_LO
    } state_t;

    localparam logic [3:0] QLAST = 4'(FILTER_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_qcnt;
    logic [3:0]           w_qcnt_nxt;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_pulse;
    logic                 r_level;
    logic                 r_rise;
    logic                 r_fall;
    logic [CNT_WIDTH-1:0] r_rise_cnt;
    logic [CNT_WIDTH-1:0] r_fall_cnt;
    logic                 r_sat;
    logic [TS_WIDTH-1:0]  r_ts;
    logic                 r_evt_valid;
    logic                 r_evt_rise;
    logic [TS_WIDTH-1:0]  r_evt_time;
    logic                 r_dropped;

    always_ff @(posedge clk_B) begin
        if (reset) begin
            r_state <= STABLE_LO;
            r_qcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (B_sync) begin
                    if (FILTER_CYCLES == 1) begin
                        w_state_nxt = STABLE_HI;
                        w_rise      = 1'b1;
                    end else begin
                        w_state_nxt = QUAL_HI;
                        w_qcnt_nxt  = 4'd1;
                    end
                end
            end
            QUAL_HI: begin
                if (!B_sync) begin
                    w_state_nxt = STABLE_LO;
                    w_qcnt_nxt  = '0;
                end else if (r_qcnt == QLAST) begin
                    w_state_nxt = STABLE_HI;
                    w_qcnt_nxt  = '0;
                    w_rise      = 1'b1;
                end else begin
                    w_qcnt_nxt  = r_qcnt + 4'd1;
                end
            end
            STABLE_HI: begin
                if (!B_sync) begin
                    if (FILTER_CYCLES == 1) begin
                        w_state_nxt = STABLE_LO;
                        w_fall      = 1'b1;
                    end else begin
                        w_state_nxt = QUAL_LO;
                        w_qcnt_nxt  = 4'd1;
                    end
                end
            end
            QUAL_LO: begin
                if (B_sync) begin
                    w_state_nxt = STABLE_HI;
                    w_qcnt_nxt  = '0;
                end else if (r_qcnt == QLAST) begin
                    w_state_nxt = STABLE_LO;
                    w_qcnt_nxt  = '0;
                    w_fall      = 1'b1;
                end else begin
                    w_qcnt_nxt  = r_qcnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_qcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_B) begin
        if (reset) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_ts    <= '0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
            r_ts   <= r_ts + TS_WIDTH'(1);
            if (w_rise)
                r_level <= 1'b1;
            else if (w_fall)
                r_level <= 1'b0;
        end
    end

    // Counters, sticky flags and the event register react to the registered strobes.
    assign w_pulse = r_rise | r_fall;

    always_ff @(posedge clk_B) begin
        if (reset || clear) begin
            r_rise_cnt <= '0;
            r_fall_cnt <= '0;
            r_sat      <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            if (r_rise) begin
                if (&r_rise_cnt)
                    r_sat <= 1'b1;
                else
                    r_rise_cnt <= r_rise_cnt + CNT_WIDTH'(1);
            end
            if (r_fall) begin
                if (&r_fall_cnt)
                    r_sat <= 1'b1;
                else
                    r_fall_cnt <= r_fall_cnt + CNT_WIDTH'(1);
            end
            if (w_pulse && r_evt_valid && !evt_ready)
                r_dropped <= 1'b1;
        end
    end

    always_ff @(posedge clk_B) begin
        if (reset) begin
            r_evt_valid <= 1'b0;
            r_evt_rise  <= 1'b0;
            r_evt_time  <= '0;
        end else if (w_pulse) begin
            if (!r_evt_valid || evt_ready) begin
                r_evt_valid <= 1'b1;
                r_evt_rise  <= r_rise;
                r_evt_time  <= r_ts;
            end
        end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign level       = r_level;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign rise_count  = r_rise_cnt;
    assign fall_count  = r_fall_cnt;
    assign count_sat   = r_sat;
    assign evt_valid   = r_evt_valid;
    assign evt_rise    = r_evt_rise;
    assign evt_time    = r_evt_time;
    assign evt_dropped = r_dropped;

endmodule

// File: tb/tb_edge_qualifier.sv
// Bench for edge_qualifier: directed scenarios plus random traffic, every cycle compared
// against a run-length reference model of the filter, counters and event register.
module tb_edge_qualifier;

    localparam int unsigned FC = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = 16;

    logic          clk_B = 1'b0;
    logic          reset = 1'b1;
    logic          B_sync = 1'b0;
    logic          clear = 1'b0;
    logic          evt_ready = 1'b0;
    logic          level;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] rise_count;
    logic [CW-1:0] fall_count;
    logic          count_sat;
    logic          evt_valid;
    logic          evt_rise;
    logic [TW-1:0] evt_time;
    logic          evt_dropped;

    edge_qualifier #(
        .FILTER_CYCLES(FC),
        .CNT_WIDTH    (CW),
        .TS_WIDTH     (TW)
    ) dut (
        .clk_B      (clk_B),
        .reset      (reset),
        .B_sync     (B_sync),
        .clear      (clear),
        .level      (level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .rise_count (rise_count),
        .fall_count (fall_count),
        .count_sat  (count_sat),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_rise   (evt_rise),
        .evt_time   (evt_time),
        .evt_dropped(evt_dropped)
    );

    always #5 clk_B = ~clk_B;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: accepted level plus length of the current disagreeing run.
    bit          m_lvl;
    int          m_run;
    bit          m_rp;
    bit          m_fp;
    int          m_rc;
    int          m_fc;
    bit          m_sat;
    logic [15:0] m_ts;
    bit          m_ev;
    bit          m_er;
    logic [15:0] m_et;
    bit          m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit b, input bit clr, input bit rdy, input bit rst);
        int cmax;
        cmax = (1 << CW) - 1;
        if (rst) begin
            m_lvl = 0; m_run = 0; m_rp = 0; m_fp = 0; m_rc = 0; m_fc = 0;
            m_sat = 0; m_ts = 0; m_ev = 0; m_er = 0; m_et = 0; m_drop = 0;
            return;
        end
        // Consequences of the strobes visible during the cycle just ended
        if (clr) begin
            m_rc = 0; m_fc = 0; m_sat = 0; m_drop = 0;
        end else begin
            if (m_rp) begin
                if (m_rc == cmax) m_sat = 1; else m_rc = m_rc + 1;
            end
            if (m_fp) begin
                if (m_fc == cmax) m_sat = 1; else m_fc = m_fc + 1;
            end
            if ((m_rp || m_fp) && m_ev && !rdy) m_drop = 1;
        end
        if (m_rp || m_fp) begin
            if (!m_ev || rdy) begin
                m_ev = 1; m_er = m_rp; m_et = m_ts;
            end
        end else if (m_ev && rdy) begin
            m_ev = 0;
        end
        m_ts = m_ts + 16'd1;
        // Filter: accept a new level after FC consecutive disagreeing samples
        m_rp = 0; m_fp = 0;
        if (b != m_lvl) begin
            m_run = m_run + 1;
            if (m_run == FC) begin
                m_lvl = b; m_run = 0;
                m_rp = b; m_fp = !b;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic step(input bit b, input bit clr, input bit rdy, input bit rst);
        reset = rst; B_sync = b; clear = clr; evt_ready = rdy;
        @(posedge clk_B);
        model_step(b, clr, rdy, rst);
        #1;
        check("level",       level,       m_lvl);
        check("rise_pulse",  rise_pulse,  m_rp);
        check("fall_pulse",  fall_pulse,  m_fp);
        check("rise_count",  rise_count,  m_rc);
        check("fall_count",  fall_count,  m_fc);
        check("count_sat",   count_sat,   m_sat);
        check("evt_valid",   evt_valid,   m_ev);
        check("evt_rise",    evt_rise,    m_er);
        check("evt_time",    evt_time,    m_et);
        check("evt_dropped", evt_dropped, m_drop);
    endtask

    initial begin
        int pulse_at;
        int hold;
        bit b;
        pulse_at = -1;

        // Reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_level", level, 0);
        check("rst_ts_evt", evt_time, 0);

        // First qualified rise after release, event held (consumer not ready)
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        check("r036_cnt", rise_count, 1);
        check("r036_valid", evt_valid, 1);
        check("r036_type", evt_rise, 1);

        // Fall, event consumed, then a 2-cycle glitch that must be rejected
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        check("r036_drain", evt_valid, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("r037_level", level, 0);
        check("r037_valid", evt_valid, 0);
        check("r037_cnt", rise_count, 1);

        // Saturation of both counters, then clear
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
            for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        end
        check("r038_cnt", rise_count, 15);
        check("r038_sat", count_sat, 1);
        step(0, 1, 1, 0);
        check("r038_clr_cnt", rise_count, 0);
        check("r038_clr_sat", count_sat, 0);

        // Backpressure: rise held, fall dropped, then one ready cycle drains
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("r039_type", evt_rise, 1);
        check("r039_drop", evt_dropped, 1);
        step(0, 0, 1, 0);
        check("r039_valid", evt_valid, 0);

        // Reset in the middle of qualification, then clear coincident with the pulse
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        check("r040_level", level, 0);
        for (int i = 1; i <= 6; i++) begin
            step(1, m_rp, 1, 0);
            if (m_rp && pulse_at < 0) pulse_at = i;
        end
        check("r040_lat", pulse_at, 3);
        check("r040_cnt", rise_count, 0);

        // Random traffic
        b = 0;
        for (int n = 0; n < 400; n++) begin
            b = ($urandom_range(0, 1) == 1);
            hold = $urandom_range(1, 5);
            for (int i = 0; i < hold; i++)
                step(b, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
